// File: rtl/uart_tx_scheduler_if.sv
// FIFO read port and serializer handshake shared by the TX scheduler.
// master: the scheduler side. slave: the FIFO/serializer side.
interface uart_tx_scheduler_if #(
    parameter int DW = 8
);
    logic          i_fifo_empty;
    logic          i_fifo_valid;
    logic [DW-1:0] i_fifo_data;
    logic          i_fifo_parity_error;
    logic          o_fifo_rd_req;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;

    modport master (
        input  i_fifo_empty,
        input  i_fifo_valid,
        input  i_fifo_data,
        input  i_fifo_parity_error,
        input  i_tx_ready,
        output o_fifo_rd_req,
        output o_tx_data,
        output o_tx_valid
    );

    modport slave (
        output i_fifo_empty,
        output i_fifo_valid,
        output i_fifo_data,
        output i_fifo_parity_error,
        output i_tx_ready,
        input  o_fifo_rd_req,
        input  o_tx_data,
        input  o_tx_valid
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Drains the TX FIFO into the serializer: one read per frame, parity-bad
// words are dropped and counted, an optional idle gap follows each frame,
// and a flush discards everything still queued.
module uart_tx_scheduler #(
    parameter int DW        = 8,
    parameter int GAP_W     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_flush,
    input  logic [GAP_W-1:0]     i_gap_cycles,
    input  logic                 i_err_clr,
    uart_tx_scheduler_if.master  bus,
    output logic                 o_busy,
    output logic                 o_drop_pulse,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_GAP     = 3'd4,
        ST_FLUSH   = 3'd5
    } state_e;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    state_e               state_q, state_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [DW-1:0]        tx_data_q, tx_data_d;
    logic                 drop_q, drop_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 err_inc_s;

    // Next-state, datapath loads and the saturating drop counter.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        tx_data_d = tx_data_q;
        drop_d    = 1'b0;
        err_inc_s = 1'b0;
        err_d     = err_q;

        if (i_flush) begin
            // Flush overrides everything, including a drop in WAIT.
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_enable && !bus.i_fifo_empty) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i_fifo_valid && bus.i_fifo_parity_error) begin
                        err_inc_s = 1'b1;
                        drop_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (bus.i_fifo_valid) begin
                        tx_data_d = bus.i_fifo_data;
                        state_d   = ST_PRESENT;
                    end else begin
                        // FIFO broke its latency promise; give up on this fetch.
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESENT: begin
                    if (bus.i_tx_ready && (i_gap_cycles == {GAP_W{1'b0}})) begin
                        state_d = ST_IDLE;
                    end else if (bus.i_tx_ready) begin
                        gap_d   = i_gap_cycles;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_PRESENT;
                    end
                end
                ST_GAP: begin
                    // Leaving while the count reads 1 makes GAP last exactly N cycles.
                    if (gap_q <= GAP_W'(1)) begin
                        gap_d   = {GAP_W{1'b0}};
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = gap_q - GAP_W'(1);
                        state_d = ST_GAP;
                    end
                end
                ST_FLUSH: begin
                    if (bus.i_fifo_empty) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A clear coinciding with a drop still records that drop.
        if (i_err_clr) begin
            err_d = err_inc_s ? ERR_CNT_W'(1) : {ERR_CNT_W{1'b0}};
        end else if (err_inc_s && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            gap_q     <= {GAP_W{1'b0}};
            tx_data_q <= {DW{1'b0}};
            drop_q    <= 1'b0;
            err_q     <= {ERR_CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

    // Output decode; the read request is gated so it never fires on an empty FIFO.
    always_comb begin
        bus.o_fifo_rd_req = ((state_q == ST_FETCH) || (state_q == ST_FLUSH)) && !bus.i_fifo_empty;
        bus.o_tx_valid    = (state_q == ST_PRESENT);
        bus.o_tx_data     = tx_data_q;
        o_busy            = (state_q != ST_IDLE);
        o_drop_pulse      = drop_q;
        o_err_cnt         = err_q;
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small behavioural FIFO model.
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       flush;
    logic [7:0] gap;
    logic       err_clr;
    logic       busy;
    logic       drop;
    logic [7:0] err_cnt;

    uart_tx_scheduler_if #(.DW(8)) bus ();

    uart_tx_scheduler #(.DW(8), .GAP_W(8), .ERR_CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_flush      (flush),
        .i_gap_cycles (gap),
        .i_err_clr    (err_clr),
        .bus          (bus),
        .o_busy       (busy),
        .o_drop_pulse (drop),
        .o_err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    logic [8:0] fq[$];      // {parity_error, data}
    logic [7:0] hs_q[$];    // words accepted by the serializer
    int         vq[$];      // cycles with o_tx_valid high
    int         rq[$];      // cycles with o_fifo_rd_req high
    int         cyc = 0;
    int         rd_cnt = 0;
    int         drop_cnt = 0;
    int         drop_cyc = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    int         n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic perr, input logic [7:0] d);
        fq.push_back({perr, d});
        bus.i_fifo_empty = 1'b0;
    endtask

    task automatic clr_logs();
        hs_q.delete();
        vq.delete();
        rq.delete();
        rd_cnt   = 0;
        drop_cnt = 0;
        drop_cyc = 0;
    endtask

    // One clock: sample handshake/read before the edge, update FIFO model after.
    task automatic step();
        logic       pop;
        logic [8:0] w;
        #1;
        pop = bus.o_fifo_rd_req && (fq.size() != 0);
        if (bus.o_tx_valid && bus.i_tx_ready) hs_q.push_back(bus.o_tx_data);
        @(posedge clk);
        cyc++;
        #1;
        if (pop) begin
            w = fq.pop_front();
            bus.i_fifo_valid        = 1'b1;
            bus.i_fifo_data         = w[7:0];
            bus.i_fifo_parity_error = w[8];
        end else begin
            bus.i_fifo_valid        = 1'b0;
            bus.i_fifo_data         = 8'h00;
            bus.i_fifo_parity_error = 1'b0;
        end
        bus.i_fifo_empty = (fq.size() == 0);
        #1;
        if (bus.o_fifo_rd_req) begin
            rd_cnt++;
            rq.push_back(cyc);
        end
        if (drop) begin
            drop_cnt++;
            drop_cyc = cyc;
        end
        if (bus.o_tx_valid) vq.push_back(cyc);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(bus.o_tx_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.o_tx_data), 32'd0);
        chk({tag, "_drop"},  32'(drop), 32'd0);
        chk({tag, "_err"},   32'(err_cnt), 32'd0);
        chk({tag, "_rdreq"}, 32'(bus.o_fifo_rd_req), 32'd0);
    endtask

    initial begin
        int t0;
        int n;
        rst                     = 1'b1;
        enable                  = 1'b0;
        flush                   = 1'b0;
        gap                     = 8'd0;
        err_clr                 = 1'b0;
        bus.i_fifo_empty        = 1'b1;
        bus.i_fifo_valid        = 1'b0;
        bus.i_fifo_data         = 8'h00;
        bus.i_fifo_parity_error = 1'b0;
        bus.i_tx_ready          = 1'b0;
        repeat (3) step();
        chk_reset("reset");
        rst = 1'b0;

        // Three back-to-back words, gap 0: valid at t+3, t+7, t+11.
        clr_logs();
        push(1'b0, 8'h11); push(1'b0, 8'h22); push(1'b0, 8'h33);
        bus.i_tx_ready = 1'b1;
        t0 = cyc;
        enable = 1'b1;
        repeat (14) step();
        chk("b2b_nvalid", 32'(vq.size()), 32'd3);
        if (vq.size() == 3) begin
            chk("b2b_v0", 32'(vq[0] - t0), 32'd3);
            chk("b2b_v1", 32'(vq[1] - t0), 32'd7);
            chk("b2b_v2", 32'(vq[2] - t0), 32'd11);
        end
        chk("b2b_nhs", 32'(hs_q.size()), 32'd3);
        if (hs_q.size() == 3) begin
            chk("b2b_d0", 32'(hs_q[0]), 32'h11);
            chk("b2b_d1", 32'(hs_q[1]), 32'h22);
            chk("b2b_d2", 32'(hs_q[2]), 32'h33);
        end
        chk("b2b_rd", 32'(rd_cnt), 32'd3);
        chk("b2b_busy", 32'(busy), 32'd0);

        // Back-pressure for 5 cycles, then gap of 3 before the next fetch.
        clr_logs();
        push(1'b0, 8'hA5); push(1'b0, 8'h3C);
        bus.i_tx_ready = 1'b0;
        gap = 8'd3;
        t0 = cyc;
        repeat (8) step();
        chk("bp_nvalid", 32'(vq.size()), 32'd6);
        if (vq.size() == 6) chk("bp_vfirst", 32'(vq[0] - t0), 32'd3);
        chk("bp_data", 32'(bus.o_tx_data), 32'hA5);
        chk("bp_nohs", 32'(hs_q.size()), 32'd0);
        bus.i_tx_ready = 1'b1;
        step();
        gap = 8'd0;
        chk("bp_gap_busy", 32'(busy), 32'd1);
        chk("bp_gap_valid", 32'(bus.o_tx_valid), 32'd0);
        repeat (7) step();
        chk("bp_nrd", 32'(rq.size()), 32'd2);
        if (rq.size() == 2) chk("bp_fetch2", 32'(rq[1] - t0), 32'd13);
        chk("bp_nhs", 32'(hs_q.size()), 32'd2);
        if (hs_q.size() == 2) begin
            chk("bp_d0", 32'(hs_q[0]), 32'hA5);
            chk("bp_d1", 32'(hs_q[1]), 32'h3C);
        end

        // Parity error word is dropped, next good word goes through.
        clr_logs();
        push(1'b1, 8'h77); push(1'b0, 8'h5A);
        t0 = cyc;
        repeat (8) step();
        chk("par_ndrop", 32'(drop_cnt), 32'd1);
        chk("par_dropcyc", 32'(drop_cyc - t0), 32'd3);
        chk("par_err", 32'(err_cnt), 32'd1);
        chk("par_nhs", 32'(hs_q.size()), 32'd1);
        if (hs_q.size() == 1) chk("par_d0", 32'(hs_q[0]), 32'h5A);
        if (vq.size() >= 1) chk("par_vcyc", 32'(vq[0] - t0), 32'd6);
        else chk("par_vcyc", 32'(vq.size()), 32'd1);

        // 300 bad words: counter saturates at 255.
        clr_logs();
        for (int i = 0; i < 300; i++) push(1'b1, 8'(i));
        n = 0;
        while (((fq.size() != 0) || busy) && (n < 1000)) begin
            step();
            n++;
        end
        chk("sat_timeout", 32'(n < 1000), 32'd1);
        chk("sat_cycles", 32'(n), 32'd900);
        chk("sat_err", 32'(err_cnt), 32'd255);
        chk("sat_ndrop", 32'(drop_cnt), 32'd300);
        chk("sat_nhs", 32'(hs_q.size()), 32'd0);

        // Clear together with a drop leaves 1; clear alone leaves 0.
        push(1'b1, 8'hEE);
        repeat (2) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_inc_err", 32'(err_cnt), 32'd1);
        chk("clr_inc_drop", 32'(drop), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_only_err", 32'(err_cnt), 32'd0);

        // Flush during PRESENT with 4 words still queued.
        clr_logs();
        bus.i_tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(1'b0, 8'(i));
        repeat (3) step();
        chk("fl_present", 32'(bus.o_tx_valid), 32'd1);
        clr_logs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid_low", 32'(bus.o_tx_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        repeat (6) step();
        chk("fl_nrd", 32'(rd_cnt), 32'd4);
        chk("fl_ndrop", 32'(drop_cnt), 32'd0);
        chk("fl_nhs", 32'(hs_q.size()), 32'd0);
        chk("fl_nvalid", 32'(vq.size()), 32'd0);
        chk("fl_idle", 32'(busy), 32'd0);
        chk("fl_empty", 32'(bus.i_fifo_empty), 32'd1);

        // Reset during GAP.
        bus.i_tx_ready = 1'b1;
        gap = 8'd5;
        push(1'b0, 8'h66);
        repeat (5) step();
        chk("rg_busy", 32'(busy), 32'd1);
        chk("rg_data", 32'(bus.o_tx_data), 32'h66);
        rst = 1'b1;
        step();
        chk_reset("rst_gap");
        rst = 1'b0;
        enable = 1'b0;
        gap = 8'd0;
        clr_logs();
        push(1'b0, 8'h44);
        repeat (3) step();
        chk("rg_no_rd", 32'(rd_cnt), 32'd0);

        // Reset during WAIT.
        enable = 1'b1;
        repeat (2) step();
        chk("rw_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk_reset("rst_wait");
        rst = 1'b0;
        enable = 1'b0;
        clr_logs();
        repeat (3) step();
        chk("rw_no_rd", 32'(rd_cnt), 32'd0);
        enable = 1'b1;
        push(1'b0, 8'h99);
        repeat (5) step();
        chk("rw_rd", 32'(rd_cnt), 32'd1);
        chk("rw_nhs", 32'(hs_q.size()), 32'd1);
        if (hs_q.size() == 1) chk("rw_d0", 32'(hs_q[0]), 32'h99);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequencing controller that drains the UART transmit FIFO into the transmit serializer. It issues single-word reads to the FIFO, absorbs the FIFO's one-cycle read latency, and drops words that fail the FIFO parity check, counting each drop. Accepted words are presented to the serializer over a valid/ready handshake, with a programmable idle gap between frames. It sits between the TX FIFO and the TX shift-register block and also provides software-driven flush and error-counter clear.

## Interface
- DW, 8, data word width; matches FIFO_DW of the attached FIFO.
- GAP_W, 8, width of inter-frame gap count.
- ERR_CNT_W, 8, width of saturating parity-drop counter.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  start new fetches when high; sampled in IDLE only.
- i_flush  in  1  discard FIFO contents and any in-flight word.
- i_gap_cycles  in  GAP_W  idle cycles inserted after each accepted frame.
- i_err_clr  in  1  clear o_err_cnt.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_valid  in  1  FIFO read-data valid, one cycle after a read request.
- i_fifo_data  in  DW  FIFO read data.
- i_fifo_parity_error  in  1  parity error for i_fifo_data, qualified by i_fifo_valid.
- o_fifo_rd_req  out  1  FIFO read request.
- o_tx_data  out  DW  word to serializer.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  serializer accepts the word when i_tx_ready and o_tx_valid are both high at a rising edge.
- o_busy  out  1  high whenever the state is not IDLE.
- o_drop_pulse  out  1  one-cycle pulse per dropped parity-error word.
- o_err_cnt  out  ERR_CNT_W  saturating count of dropped words.

## Operation
- States: IDLE, FETCH, WAIT, PRESENT, GAP, FLUSH.
- i_flush in any state: next state is FLUSH. This has priority over all other transitions.
- IDLE: moves to FETCH when i_enable and !i_fifo_empty; otherwise stays.
- FETCH: o_fifo_rd_req=1 for exactly this cycle; next state is WAIT.
- WAIT, with i_fifo_valid and !i_fifo_parity_error: latch i_fifo_data into o_tx_data; next state is PRESENT.
- WAIT, with i_fifo_valid and i_fifo_parity_error: drop the word; pulse o_drop_pulse next cycle; increment o_err_cnt; next state is IDLE.
- WAIT, with !i_fifo_valid: protocol fault; next state is IDLE; no count.
- PRESENT: o_tx_valid=1 and o_tx_data held stable until handshake.
  - On handshake with i_gap_cycles==0: next state is IDLE.
  - On handshake otherwise: load the gap counter with i_gap_cycles; next state is GAP.
- GAP: decrement the counter each cycle. Leave for IDLE in the cycle the counter equals 1, so GAP lasts exactly i_gap_cycles cycles.
- FLUSH: o_fifo_rd_req = !i_fifo_empty (combinational).
  - Returned data is discarded; no parity counting and no drop pulses.
  - Exit to IDLE when i_fifo_empty and !i_flush.
- o_tx_valid is 1 only in PRESENT. Flush during PRESENT drops o_tx_valid the next cycle; the word is not transferred.
- o_fifo_rd_req is never asserted while i_fifo_empty is high.
- i_enable deasserting mid-sequence does not abort; the in-flight word completes.
- o_err_cnt saturates at 2^ERR_CNT_W-1.
  - i_err_clr alone sets it to 0.
  - i_err_clr together with an increment sets it to 1.
- i_gap_cycles is sampled only at the handshake edge.

## Timing
- Reset: state=IDLE, o_fifo_rd_req=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_drop_pulse=0, o_err_cnt=0, gap counter=0. Reset mid-frame abandons the word with no handshake.
- Cycle t: IDLE sees enable and not-empty.
- Cycle t+1: FETCH, rd_req=1.
- Cycle t+2: WAIT, fifo_valid expected.
- Cycle t+3: PRESENT, o_tx_valid=1.
- Best-case throughput with gap=0 and ready held high is one word per 4 cycles.
- With gap=G, one word per 4+G cycles.
- o_drop_pulse is high in the cycle after the WAIT cycle, the same cycle the state returns to IDLE. o_err_cnt updates at the same edge.
- Flush takes effect at the edge where i_flush is sampled high. A FIFO holding N words drains in N FLUSH cycles plus one cycle to see empty.

## Test plan
- Load 3 words 0x11, 0x22, 0x33; set enable=1, gap=0, ready=1. Expect o_tx_valid on cycles t+3, t+7, t+11 with data in order, then IDLE with busy=0.
- Single word 0xA5 with ready held low for 5 cycles. Expect o_tx_valid and o_tx_data=0xA5 stable for 6 cycles, then a transfer on the ready edge. With gap=3, expect exactly 3 GAP cycles before the next FETCH.
- Word with injected parity error. Expect no o_tx_valid, one o_drop_pulse, o_err_cnt=1; the following good word 0x5A is transmitted normally.
- Force 300 parity-error words with ERR_CNT_W=8. Expect o_err_cnt=255 held. Assert i_err_clr together with a drop: expect o_err_cnt=1.
- FIFO holding 4 words; assert flush during PRESENT. Expect o_tx_valid low next cycle, no handshake, 4 rd_req cycles, o_drop_pulse never asserted, IDLE with FIFO empty.
- Assert i_rst during GAP and during WAIT. Expect all outputs at reset values the next cycle and no rd_req until enable and not-empty are seen again.
